booth_mult_32_pipe: RTL and testbench
=====================================

Name: booth_mult_32_pipe

Overview:
- Pipelined signed 32x32 -> 64-bit multiplier for the datapath MUL instruction.
- Uses radix-4 bit-pair (modified Booth) recoding of the multiplier into 16 partial products, reduced by a three-level 4:2 compressor tree (16->8->4->2), then summed by a 64-bit carry-lookahead adder.
- Fully pipelined: accepts one operand pair per clock; fixed latency.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH. Only 32 is supported and verified.

Ports:
- in_clk  input  1  rising-edge clock
- in_reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair on in_x/in_y is valid this cycle
- in_x  input  32  multiplicand, two's complement
- in_y  input  32  multiplier, two's complement; this operand is bit-pair recoded
- out_valid  output  1  out_product holds a new result
- out_product  output  64  signed product in_x*in_y, two's complement

Behaviour:
- Reset (asynchronous, active-high):
  - all pipeline registers clear to 0 immediately;
  - out_product = 64'h0 and out_valid = 0 while reset is asserted and after it is released.
- Stage 1 (input register): on each rising in_clk, capture in_x, in_y and in_valid unconditionally.
- Stage 2 (combinational, then output register):
  - Pad the multiplier as {y,1'b0}. For i = 0..15, recode the triplet y_pad[2i+2:2i]:
    - 000/111 -> 0
    - 001/010 -> +x
    - 011 -> +2x
    - 100 -> -2x
    - 101/110 -> -x
  - Each partial product is sign-extended to 64 bits, then shifted left by 2i with zero fill.
  - Negation is two's complement, implemented as invert plus a +1 injected in the tree or as an explicit increment. The -2x term for x = -2^31 must be exact at 64 bits.
  - Reduction tree:
    - 4:2 compressors, groups of four, 16->8->4->2;
    - the compressor carry vector is shifted left by 1 within 64 bits;
    - carries out of bit 63 are discarded (modulo 2^64 arithmetic is exact here).
  - The final 64-bit CLA has carry-in 0 and its carry-out is discarded. The result is registered into out_product, and stage-1 valid is registered into out_valid.
- Latency:
  - 2 clocks: operands presented before edge N appear on out_product after edge N+1.
  - Throughput 1/clock; no stall or back-pressure.
- Data registers load every cycle regardless of in_valid; out_valid qualifies the data.
- When in_valid = 0, out_product still shows the product of whatever was captured. Consumers must ignore it.
- Back-to-back valid inputs give back-to-back valid outputs in order.
- Reset mid-operation: all in-flight results are discarded; out_valid = 0 on the first edge after release, until new valid data propagates.
- Corner cases: 0*anything = 0; (-2^31)*(-2^31) = 64'h4000_0000_0000_0000; (-2^31)*1 = 64'hFFFF_FFFF_8000_0000.

Optional Feature:
- Macro MULT_TREE_PIPE_EN.
- When defined:
  - add a register stage between the compressor tree output (the two 64-bit vectors) and the CLA;
  - latency becomes 3 clocks;
  - valid is delayed to match;
  - this stage is also asynchronously reset to 0.
- When undefined: latency is 2 clocks, as above. Results are bit-identical in both builds.

Test Plan:
- Reset: assert in_reset with random inputs toggling -> out_product = 0 and out_valid = 0 during reset and on the first edge after release.
- Small positives: x=32'hA, y=32'hA -> 64'd100 (0x64); x=32'h61, y=32'h56 -> 64'd8342 (0x2096), each 2 clocks later (3 with MULT_TREE_PIPE_EN).
- Mixed sign: x=32'hFFFF_FFF3 (-13), y=32'hB -> 64'hFFFF_FFFF_FFFF_FF71 (-143); and x=32'hB, y=32'hFFFF_FFF3 -> same result.
- Extremes: (-2^31)*(-2^31) -> 64'h4000_0000_0000_0000; 32'h7FFF_FFFF squared -> 64'h3FFF_FFFF_0000_0001; 32'hFFFF_FFFF*32'hFFFF_FFFF -> 64'h1.
- Streaming: valid on 4 consecutive cycles with distinct operands -> 4 consecutive out_valid pulses with in-order correct products; a gap in in_valid gives a matching gap in out_valid.
- Reset mid-stream: assert in_reset while two products are in flight -> neither appears; out_valid stays 0 until new inputs are applied. Follow with 10,000 random operand pairs checked against a signed 64-bit reference model.

Source files
------------

// File: rtl/booth_mult_32_pipe.sv
// Pipelined signed 32x32->64 radix-4 Booth multiplier with a 4:2 compressor tree and a prefix CLA.
// Define MULT_TREE_PIPE_EN to register the tree outputs before the CLA (latency 3 instead of 2).
module booth_mult_32_pipe #(
   parameter int WIDTH = 32
) (
   input  logic                 in_clk,
   input  logic                 in_reset,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [WIDTH-1:0]     in_y,
   output logic                 out_valid,
   output logic [2*WIDTH-1:0]   out_product
);

   localparam int PW  = 2 * WIDTH;
   localparam int NPP = WIDTH / 2;

   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;
   logic             valid_q;
   logic [PW-1:0]    x_ext;
   logic [WIDTH:0]   y_pad;
   logic [PW-1:0]    pp [NPP];
   logic [PW-1:0]    lvl1 [8];
   logic [PW-1:0]    lvl2 [4];
   logic [PW-1:0]    tree_sum;
   logic [PW-1:0]    tree_carry;
   logic [PW-1:0]    cla_a;
   logic [PW-1:0]    cla_b;
   logic             cla_valid;
   logic [PW-1:0]    cla_sum;

   // Booth digit for one triplet; negative digits are negated in full at PW bits so -2x of -2^31 stays exact
   function automatic logic [PW-1:0] booth_term(input logic [2:0] trip, input logic [PW-1:0] xe);
      logic [PW-1:0] term;
      case (trip)
         3'b001, 3'b010: term = xe;
         3'b011:         term = xe << 1;
         3'b100:         term = ~(xe << 1) + PW'(1);
         3'b101, 3'b110: term = ~xe + PW'(1);
         default:        term = '0;
      endcase
      return term;
   endfunction

   function automatic void csa(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [PW-1:0] c,
                               output logic [PW-1:0] s, output logic [PW-1:0] cy);
      s  = a ^ b ^ c;
      cy = ((a & b) | (a & c) | (b & c)) << 1;
   endfunction

   function automatic void comp42(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                  input logic [PW-1:0] c, input logic [PW-1:0] d,
                                  output logic [PW-1:0] s, output logic [PW-1:0] cy);
      logic [PW-1:0] s1;
      logic [PW-1:0] c1;
      csa(a, b, c, s1, c1);
      csa(s1, c1, d, s, cy);
   endfunction

   // Kogge-Stone prefix carries with carry-in 0; carry out of the top bit is dropped
   function automatic logic [PW-1:0] cla_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
      logic [PW-1:0] p0;
      logic [PW-1:0] g;
      logic [PW-1:0] p;
      logic [PW-1:0] g_n;
      logic [PW-1:0] p_n;
      p0 = a ^ b;
      g  = a & b;
      p  = p0;
      for (int d = 1; d < PW; d = d * 2) begin
         g_n = g;
         p_n = p;
         for (int i = d; i < PW; i++) begin
            g_n[i] = g[i] | (p[i] & g[i-d]);
            p_n[i] = p[i] & p[i-d];
         end
         g = g_n;
         p = p_n;
      end
      return p0 ^ {g[PW-2:0], 1'b0};
   endfunction

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         x_q     <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         x_q     <= in_x;
         y_q     <= in_y;
         valid_q <= in_valid;
      end
   end

   assign x_ext = {{WIDTH{x_q[WIDTH-1]}}, x_q};
   assign y_pad = {y_q, 1'b0};

   always_comb begin
      for (int i = 0; i < NPP; i++) begin
         pp[i] = booth_term(y_pad[2*i +: 3], x_ext) << (2 * i);
      end
   end

   // 16 -> 8 -> 4 -> 2 reduction
   always_comb begin
      for (int g = 0; g < 4; g++) begin
         comp42(pp[4*g], pp[4*g+1], pp[4*g+2], pp[4*g+3], lvl1[2*g], lvl1[2*g+1]);
      end
      for (int g = 0; g < 2; g++) begin
         comp42(lvl1[4*g], lvl1[4*g+1], lvl1[4*g+2], lvl1[4*g+3], lvl2[2*g], lvl2[2*g+1]);
      end
      comp42(lvl2[0], lvl2[1], lvl2[2], lvl2[3], tree_sum, tree_carry);
   end

`ifdef MULT_TREE_PIPE_EN
   logic [PW-1:0] tree_sum_q;
   logic [PW-1:0] tree_carry_q;
   logic          tree_valid_q;

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         tree_sum_q   <= '0;
         tree_carry_q <= '0;
         tree_valid_q <= 1'b0;
      end else begin
         tree_sum_q   <= tree_sum;
         tree_carry_q <= tree_carry;
         tree_valid_q <= valid_q;
      end
   end

   assign cla_a     = tree_sum_q;
   assign cla_b     = tree_carry_q;
   assign cla_valid = tree_valid_q;
`else
   assign cla_a     = tree_sum;
   assign cla_b     = tree_carry;
   assign cla_valid = valid_q;
`endif

   assign cla_sum = cla_add(cla_a, cla_b);

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         out_product <= '0;
         out_valid   <= 1'b0;
      end else begin
         out_product <= cla_sum;
         out_valid   <= cla_valid;
      end
   end

endmodule

// File: tb/tb_booth_mult_32_pipe.sv
// Scoreboard bench for booth_mult_32_pipe: directed corners, streaming, resets and random pairs
// checked against plain signed 64-bit multiplication.
module tb_booth_mult_32_pipe;

`ifdef MULT_TREE_PIPE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        in_clk = 1'b0;
   logic        in_reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_x = '0;
   logic [31:0] in_y = '0;
   logic        out_valid;
   logic [63:0] out_product;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [63:0] exp;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   num_vec = 0;
   int   num_err = 0;

   booth_mult_32_pipe #(.WIDTH(32)) dut (
      .in_clk      (in_clk),
      .in_reset    (in_reset),
      .in_valid    (in_valid),
      .in_x        (in_x),
      .in_y        (in_y),
      .out_valid   (out_valid),
      .out_product (out_product)
   );

   always #5 in_clk = ~in_clk;

   always @(posedge in_clk) cyc <= cyc + 1;

   function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
      longint a;
      longint b;
      a = longint'($signed(x));
      b = longint'($signed(y));
      return 64'(a * b);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      num_vec++;
      if (act !== exp) begin
         num_err++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one slot just after the falling edge; expected values are pushed with their due cycle
   task automatic applyStimulus(input logic v, input logic [31:0] x, input logic [31:0] y,
                                input logic use_exp, input logic [63:0] exp);
      exp_t e;
      @(negedge in_clk);
      #1;
      in_valid = v;
      in_x     = x;
      in_y     = y;
      if (v) begin
         e.x   = x;
         e.y   = y;
         e.exp = use_exp ? exp : model(x, y);
         e.due = cyc + LAT;
         sb.push_back(e);
      end
   endtask

   task automatic holdReset(input int n);
      repeat (n) begin
         @(negedge in_clk);
         #1;
         in_x     = $urandom;
         in_y     = $urandom;
         in_valid = 1'($urandom);
      end
      @(negedge in_clk);
      #1;
      in_reset = 1'b0;
      in_valid = 1'b0;
      @(negedge in_clk);
      checkOutput("post_reset_valid", {63'b0, out_valid}, 64'd0);
      checkOutput("post_reset_product", out_product, 64'd0);
   endtask

   // Monitor: every valid output pops the oldest expectation and must arrive on its due cycle
   always @(negedge in_clk) begin
      exp_t e;
      if (in_reset) begin
         checkOutput("reset_valid", {63'b0, out_valid}, 64'd0);
         checkOutput("reset_product", out_product, 64'd0);
      end else if (out_valid) begin
         if (sb.size() == 0) begin
            num_vec++;
            num_err++;
            $display("[TB] FAIL unexpected_valid: got product %h with no pending operand (cycle %0d)",
                     out_product, cyc);
         end else begin
            e = sb.pop_front();
            checkOutput($sformatf("product %h*%h", e.x, e.y), out_product, e.exp);
            checkOutput("latency_cycle", 64'(cyc), 64'(e.due));
         end
      end
   end

   logic [31:0] dir_x [10];
   logic [31:0] dir_y [10];
   logic [63:0] dir_p [10];
   logic [31:0] corner [6];

   initial begin
      dir_x = '{32'hA, 32'h61, 32'hFFFF_FFF3, 32'hB, 32'h8000_0000, 32'h7FFF_FFFF,
                32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1234_5678};
      dir_y = '{32'hA, 32'h56, 32'hB, 32'hFFFF_FFF3, 32'h8000_0000, 32'h7FFF_FFFF,
                32'hFFFF_FFFF, 32'h8765_4321, 32'h1, 32'h0};
      dir_p = '{64'd100, 64'd8342, 64'hFFFF_FFFF_FFFF_FF71, 64'hFFFF_FFFF_FFFF_FF71,
                64'h4000_0000_0000_0000, 64'h3FFF_FFFF_0000_0001, 64'h1, 64'h0,
                64'hFFFF_FFFF_8000_0000, 64'h0};
      corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5555_5555};

      in_reset = 1'b1;
      holdReset(3);

      // directed corners, each separated by an idle slot to exercise gaps
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, dir_x[i], dir_y[i], 1'b1, dir_p[i]);
         applyStimulus(1'b0, $urandom, $urandom, 1'b0, 64'd0);
      end

      // back-to-back stream, a gap, then more
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, $urandom, $urandom, 1'b0, 64'd0);
      applyStimulus(1'b0, $urandom, $urandom, 1'b0, 64'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom, $urandom, 1'b0, 64'd0);
      repeat (LAT + 1) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 64'd0);

      // reset while two products are in flight: neither may emerge
      applyStimulus(1'b1, 32'h1234, 32'h5678, 1'b0, 64'd0);
      applyStimulus(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 64'd0);
      #2;
      in_reset = 1'b1;
      sb.delete();
      holdReset(2);
      repeat (3) applyStimulus(1'b0, $urandom, $urandom, 1'b0, 64'd0);

      for (int i = 0; i < 10000; i++) begin
         logic [31:0] rx;
         logic [31:0] ry;
         rx = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         ry = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         applyStimulus(1'($urandom_range(0, 9) != 0), rx, ry, 1'b0, 64'd0);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 64'd0);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge in_clk);
      @(negedge in_clk);
      checkOutput("drain_pending", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_err);
      $finish;
   end

endmodule
